// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the divide-by-zero quotient fill.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Divide by zero returns an all-ones quotient at any width.
    localparam logic DIV0_QUO_FILL = 1'b1;

    function automatic logic isSignedOp(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic isDivOp(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/result bundle between the pipeline and muldiv_iter.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, flush, a, b,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, flush, a, b,
                    output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_twos_neg.sv
// Conditional two's-complement negate used for all sign conditioning.
module twos_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);
    assign result = neg ? (~value + W'(1)) : value;
endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide engine: magnitudes in, one step per cycle,
// sign-corrected hi/lo registered on the final step.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t              state;
    logic [CW-1:0]       stepCnt;
    logic                isDiv;
    logic                negRes;
    logic                negRem;
    logic                divZero;
    logic [WIDTH-1:0]    opnd;
    logic [2*WIDTH-1:0]  acc;
    logic [WIDTH:0]      rem;
    logic                doneReg;
    logic [WIDTH-1:0]    hiReg;
    logic [WIDTH-1:0]    loReg;

    logic                sgnOp;
    logic [WIDTH-1:0]    aMag;
    logic [WIDTH-1:0]    bMag;

    assign sgnOp = isSignedOp(bus.op);

    twos_neg #(.W(WIDTH)) uAbsA (.value(bus.a), .neg(sgnOp & bus.a[WIDTH-1]), .result(aMag));
    twos_neg #(.W(WIDTH)) uAbsB (.value(bus.b), .neg(sgnOp & bus.b[WIDTH-1]), .result(bMag));

    // acc: multiply keeps {partial sum, multiplier}; divide keeps the
    // dividend in the low half and shifts quotient bits in behind it.
    logic [WIDTH:0]      addSum;
    logic [WIDTH:0]      remShift;
    logic [WIDTH:0]      remDiff;
    logic [2*WIDTH-1:0]  accNext;
    logic [WIDTH:0]      remNext;

    always_comb begin
        addSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        remShift = {rem[WIDTH-1:0], acc[WIDTH-1]};
        remDiff  = remShift - {1'b0, opnd};
        accNext  = acc;
        remNext  = rem;
        if (isDiv) begin
            if (remDiff[WIDTH]) begin
                remNext = remShift;
                accNext = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
            end else begin
                remNext = remDiff;
                accNext = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            accNext = {addSum, acc[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0]  prodFix;
    logic [WIDTH-1:0]    quoFix;
    logic [WIDTH-1:0]    remFix;

    twos_neg #(.W(2*WIDTH)) uNegProd (.value(accNext),              .neg(negRes), .result(prodFix));
    twos_neg #(.W(WIDTH))   uNegQuo  (.value(accNext[WIDTH-1:0]),   .neg(negRes), .result(quoFix));
    twos_neg #(.W(WIDTH))   uNegRem  (.value(remNext[WIDTH-1:0]),   .neg(negRem), .result(remFix));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            stepCnt <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            rem     <= '0;
            doneReg <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            doneReg <= 1'b0;
            if (bus.flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state   <= ST_RUN;
                            stepCnt <= '0;
                            isDiv   <= isDivOp(bus.op);
                            negRes  <= sgnOp & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            negRem  <= sgnOp & bus.a[WIDTH-1];
                            divZero <= (bus.b == '0);
                            opnd    <= bMag;
                            acc     <= {{WIDTH{1'b0}}, aMag};
                            rem     <= '0;
                        end
                    end
                    ST_RUN: begin
                        acc     <= accNext;
                        rem     <= remNext;
                        stepCnt <= stepCnt + 1'b1;
                        if (stepCnt == LAST_STEP) begin
                            state   <= ST_DONE;
                            doneReg <= 1'b1;
                            if (isDiv) begin
                                // Zero divisor: remainder path already yields a.
                                hiReg <= remFix;
                                loReg <= divZero ? {WIDTH{DIV0_QUO_FILL}} : quoFix;
                            end else begin
                                hiReg <= prodFix[2*WIDTH-1:WIDTH];
                                loReg <= prodFix[WIDTH-1:0];
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = ((state == ST_IDLE) && bus.start && !bus.flush) || (state == ST_RUN);
    assign bus.done = doneReg;
    assign bus.hi   = hiReg;
    assign bus.lo   = loReg;

endmodule
